// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: STAGES cascaded valid/ready slices, each a main register plus a skid entry.
// Optional ELASTIC_PIPE_PERF_EN adds stall/flush counters and an occupancy output.

module elastic_pipe_slice #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl
);
    logic              mv, sv;
    logic [DATA_W-1:0] md, sd;
    logic [CTRL_W-1:0] mc, sc;

    // Ready comes only from the skid flag, so out_ready never reaches in_ready combinationally.
    assign up_ready = ~sv;
    assign dn_valid = mv;
    assign dn_data  = md;
    assign dn_ctrl  = mv ? mc : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            mv <= 1'b0;
            sv <= 1'b0;
            md <= '0;
            mc <= '0;
            sd <= '0;
            sc <= '0;
        end else if (flush) begin
            mv <= 1'b0;
            sv <= 1'b0;
        end else if (!mv || dn_ready) begin
            // Main is free this cycle: the older skid entry takes priority over the input.
            if (sv) begin
                mv <= 1'b1;
                md <= sd;
                mc <= sc;
                sv <= 1'b0;
            end else begin
                mv <= up_valid;
                if (up_valid) begin
                    md <= up_data;
                    mc <= up_ctrl;
                end
            end
        end else if (up_valid && !sv) begin
            sv <= 1'b1;
            sd <= up_data;
            sc <= up_ctrl;
        end
    end
endmodule

module elastic_pipe_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    output logic [31:0]                     stall_cnt,
    output logic [15:0]                     flush_cnt,
    output logic [$clog2(2*STAGES+1)-1:0]   occupancy
`endif
);
    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("elastic_pipe_reg: STAGES must be in 1..4");
        end
    endgenerate

    // Index i is the boundary feeding slice i; index STAGES is the block output.
    logic [STAGES:0]             vld, rdy;
    logic [STAGES:0][DATA_W-1:0] dat;
    logic [STAGES:0][CTRL_W-1:0] ctl;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign ctl[0]      = in_ctrl;
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        elastic_pipe_slice #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slice (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .up_data  (dat[i]),
            .up_ctrl  (ctl[i]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1]),
            .dn_data  (dat[i+1]),
            .dn_ctrl  (ctl[i+1])
        );
    end

    assign in_ready  = rdy[0] & ~reset;
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];
    assign out_ctrl  = ctl[STAGES];

`ifdef ELASTIC_PIPE_PERF_EN
    localparam int OCC_W = $clog2(2*STAGES+1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    // A slice's skid is full exactly when its upstream ready is low.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++)
            occupancy = occupancy + OCC_W'(vld[i+1]) + OCC_W'(~rdy[i]);
    end
`endif
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: three instances (STAGES=1,2,3) checked against an in-order queue model.
`timescale 1ns/1ps
module tb_elastic_pipe_reg;
    logic        clk = 1'b0;
    logic        reset;
    logic        iv[3], ir[3], ov[3], orr[3], fl[3];
    logic [95:0] id[3], od[3];
    logic [7:0]  ic[3], oc[3];
`ifdef ELASTIC_PIPE_PERF_EN
    logic [31:0] stc[3];
    logic [15:0] flc[3];
    logic [1:0]  occ0;
    logic [2:0]  occ1, occ2;
`endif

    int checks = 0, failures = 0;
    int nout, nacc, cyc;
    int out_idx[$];
    logic [103:0] q[$];
    logic last_fin, last_ir, last_fout, prev_stall;
    logic [103:0] prev_out;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.DATA_W(96), .CTRL_W(8), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_ctrl(ic[0]), .flush(fl[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .out_ctrl(oc[0])
`ifdef ELASTIC_PIPE_PERF_EN
        , .stall_cnt(stc[0]), .flush_cnt(flc[0]), .occupancy(occ0)
`endif
    );
    elastic_pipe_reg #(.DATA_W(96), .CTRL_W(8), .STAGES(2)) u_s2 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_ctrl(ic[1]), .flush(fl[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .out_ctrl(oc[1])
`ifdef ELASTIC_PIPE_PERF_EN
        , .stall_cnt(stc[1]), .flush_cnt(flc[1]), .occupancy(occ1)
`endif
    );
    elastic_pipe_reg #(.DATA_W(96), .CTRL_W(8), .STAGES(3)) u_s3 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_ctrl(ic[2]), .flush(fl[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(od[2]), .out_ctrl(oc[2])
`ifdef ELASTIC_PIPE_PERF_EN
        , .stall_cnt(stc[2]), .flush_cnt(flc[2]), .occupancy(occ2)
`endif
    );

    // One cycle on instance k: inputs already driven; called and returns at a negedge.
    task automatic step(input int k);
        logic r0;
        logic [103:0] exp_v;
        #1;
        r0 = ir[k];
        orr[k] = ~orr[k];
        #1;
        checks++;
        if (ir[k] !== r0) begin
            failures++;
            $display("FAIL comb_ready inst=%0d got=%b want=%b", k, ir[k], r0);
        end
        orr[k] = ~orr[k];
        #1;
        last_ir   = ir[k];
        last_fin  = iv[k] && ir[k];
        last_fout = ov[k] && orr[k];
        if (!ov[k]) begin
            checks++;
            if (oc[k] !== 8'h00) begin
                failures++;
                $display("FAIL bubble_ctrl inst=%0d got=%h want=00", k, oc[k]);
            end
        end
        if (prev_stall) begin
            checks++;
            if (ov[k] !== 1'b1 || {oc[k], od[k]} !== prev_out) begin
                failures++;
                $display("FAIL hold_stable inst=%0d got=%b/%h want=1/%h", k, ov[k], {oc[k], od[k]}, prev_out);
            end
        end
        prev_stall = ov[k] && !orr[k] && !fl[k];
        prev_out   = {oc[k], od[k]};
        if (last_fout) begin
            nout++;
            out_idx.push_back(cyc);
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL spurious_out inst=%0d got=%h want=none", k, {oc[k], od[k]});
            end else begin
                exp_v = q.pop_front();
                if ({oc[k], od[k]} !== exp_v) begin
                    failures++;
                    $display("FAIL out_order inst=%0d got=%h want=%h", k, {oc[k], od[k]}, exp_v);
                end
            end
        end
        if (fl[k]) q.delete();
        else if (last_fin) q.push_back({ic[k], id[k]});
        if (last_fin) nacc++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        q.delete();
        out_idx.delete();
        nout = 0; nacc = 0; cyc = 0;
        prev_stall = 1'b0; last_fin = 1'b0; last_ir = 1'b0; last_fout = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; fl[k] = 1'b0; id[k] = '0; ic[k] = '0;
        end
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ir[k] !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_reset inst=%0d got=%b want=0", k, ir[k]);
            end
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || od[k] !== 96'h0 || oc[k] !== 8'h0 || ir[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_state inst=%0d got=v%b d%h c%h r%b want=v0 d0 c0 r1",
                         k, ov[k], od[k], oc[k], ir[k]);
            end
        end
        clear_model();
    endtask

    task automatic test_latency();
        logic [95:0] vals[3];
        int i = 0;
        vals[0] = 96'h11; vals[1] = 96'h22; vals[2] = 96'h33;
        test_reset();
        orr[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            iv[1] = (i < 3);
            id[1] = (i < 3) ? vals[i] : '0;
            ic[1] = 8'(i + 1);
            step(1);
            if (last_fin) i++;
        end
        iv[1] = 1'b0;
        checks++;
        if (nout !== 3 || out_idx.size() != 3) begin
            failures++;
            $display("FAIL latency_count got=%0d want=3", nout);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (out_idx[j] != j + 2) begin
                    failures++;
                    $display("FAIL latency_cycle idx=%0d got=%0d want=%0d", j, out_idx[j], j + 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int i = 0;
        int c = 0;
        test_reset();
        orr[0] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            iv[0] = 1'b1; id[0] = 96'(100 + i); ic[0] = 8'(i);
            step(0);
            if (last_fin) i++;
            if (t == 2) begin
                checks++;
                if (last_ir !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_fall got=%b want=0", last_ir);
                end
            end
        end
        checks++;
        if (nacc != 2 || last_ir !== 1'b0) begin
            failures++;
            $display("FAIL capacity_s1 got=%0d/%b want=2/0", nacc, last_ir);
        end
        orr[0] = 1'b1;
        while ((i < 5 || q.size() != 0) && c < 40) begin
            iv[0] = (i < 5); id[0] = 96'(100 + i); ic[0] = 8'(i);
            step(0);
            if (last_fin) i++;
            c++;
        end
        iv[0] = 1'b0;
        checks++;
        if (nout != 5 || nacc != 5) begin
            failures++;
            $display("FAIL drain_all got=%0d/%0d want=5/5", nout, nacc);
        end
    endtask

    task automatic test_random();
        int c = 0;
        test_reset();
        while (nout < 10000 && c < 60000) begin
            if (!(iv[2] && !last_fin)) begin
                iv[2] = (nacc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                id[2] = {$urandom, $urandom, $urandom};
                ic[2] = 8'($urandom);
            end
            if (last_fin && nacc >= 10000) iv[2] = 1'b0;
            orr[2] = 1'($urandom_range(0, 1));
            step(2);
            c++;
        end
        iv[2] = 1'b0;
        checks++;
        if (nout != 10000 || q.size() != 0) begin
            failures++;
            $display("FAIL random_total got=%0d left=%0d want=10000 left=0", nout, q.size());
        end
    endtask

    task automatic test_flush();
        int i = 0;
        test_reset();
        orr[1] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            iv[1] = 1'b1; id[1] = 96'(i + 1); ic[1] = 8'hFF;
            step(1);
            if (last_fin) i++;
        end
        checks++;
        if (nacc != 4 || last_ir !== 1'b0) begin
            failures++;
            $display("FAIL capacity_s2 got=%0d/%b want=4/0", nacc, last_ir);
        end
        fl[1] = 1'b1; id[1] = 96'hDEAD;
        step(1);
        fl[1] = 1'b0; iv[1] = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || oc[1] !== 8'h00 || ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear got=v%b c%h r%b want=v0 c00 r1", ov[1], oc[1], ir[1]);
        end
        // Entry accepted during a flush is discarded.
        iv[1] = 1'b1; id[1] = 96'hA1; ic[1] = 8'h5A;
        step(1);
        fl[1] = 1'b1; id[1] = 96'hBEEF;
        step(1);
        fl[1] = 1'b0; iv[1] = 1'b0; orr[1] = 1'b1;
        for (int t = 0; t < 8; t++) step(1);
        checks++;
        if (nout != 0) begin
            failures++;
            $display("FAIL flush_discard got=%0d want=0", nout);
        end
        // Downstream transfer in the flush cycle still completes.
        iv[1] = 1'b1; id[1] = 96'hC3; ic[1] = 8'h81;
        step(1);
        iv[1] = 1'b0;
        step(1);
        fl[1] = 1'b1;
        step(1);
        fl[1] = 1'b0;
        for (int t = 0; t < 4; t++) step(1);
        checks++;
        if (nout != 1) begin
            failures++;
            $display("FAIL flush_out_xfer got=%0d want=1", nout);
        end
    endtask

    task automatic test_reset_midstream();
        test_reset();
        orr[1] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            iv[1] = 1'b1; id[1] = 96'(t + 40); ic[1] = 8'hC0;
            step(1);
        end
        iv[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        checks++;
        if (ov[1] !== 1'b0 || od[1] !== 96'h0 || oc[1] !== 8'h0) begin
            failures++;
            $display("FAIL reset_mid got=v%b d%h c%h want=v0 d0 c0", ov[1], od[1], oc[1]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready got=%b want=1", ir[1]);
        end
        clear_model();
        orr[1] = 1'b1;
        for (int t = 0; t < 6; t++) step(1);
        checks++;
        if (nout != 0) begin
            failures++;
            $display("FAIL reset_mid_drop got=%0d want=0", nout);
        end
    endtask

`ifdef ELASTIC_PIPE_PERF_EN
    task automatic test_perf();
        test_reset();
        orr[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 96'h77; ic[1] = 8'h01;
        step(1);
        iv[1] = 1'b0;
        step(1);
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (ov[1] !== 1'b1) begin
                failures++;
                $display("FAIL perf_stall_valid t=%0d got=%b want=1", t, ov[1]);
            end
            step(1);
        end
        checks++;
        if (occ1 !== 3'd1) begin
            failures++;
            $display("FAIL perf_occ_mid got=%0d want=1", occ1);
        end
        orr[1] = 1'b1;
        step(1);
        fl[1] = 1'b1; step(1);
        fl[1] = 1'b0; step(1);
        fl[1] = 1'b1; step(1);
        fl[1] = 1'b0;
        #1;
        checks++;
        if (stc[1] !== 32'd7 || flc[1] !== 16'd2 || occ1 !== 3'd0) begin
            failures++;
            $display("FAIL perf_counts got=%0d/%0d/%0d want=7/2/0", stc[1], flc[1], occ1);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_midstream();
`ifdef ELASTIC_PIPE_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
